move_link_ctrl: RTL and testbench

Turn scheduler and move-transfer controller for the two-console Connect-4 link. It owns the single serial wire in each direction (`tx` out, `rx` in) and decides whose turn it is. It serialises the local player's column choice to the remote console and waits for its acknowledge. It also deserialises the remote console's move, acknowledges it, and hands it to the game logic. It sits between the connection-handshake block (which supplies `link_up`) and the board/game FSM.

---
 rtl/move_link_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_move_link_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : move_link_ctrl
// Purpose  : Turn scheduler and move-transfer controller for the two-console
//            Connect-4 link. Serialises local moves, waits for their ACK
//            (with timeout/resend), receives remote moves and ACKs them.
// Ports    : clk_i/rst_ni        - clock, async active-low reset
//            player_i            - 1 = this console moves first
//            link_up_i/restart_i - link state / synchronous game clear
//            local_*             - local move handshake (+ illegal_move_o)
//            remote_*            - remote move delivery
//            my_turn_o           - local console may move
//            link_error_o        - sticky error (retries or bad frame)
//            tx_o/rx_i           - serial lines, idle low
// Revision : 1.0 - initial release
// ============================================================================
module move_link_ctrl #(
    parameter int BIT_CYCLES  = 8,
    parameter int ACK_TIMEOUT = 1024,
    parameter int RETRIES     = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       player_i,
    input  logic       link_up_i,
    input  logic       restart_i,
    input  logic       local_valid_i,
    input  logic [2:0] local_col_i,
    output logic       local_ready_o,
    output logic       illegal_move_o,
    output logic       remote_valid_o,
    output logic [2:0] remote_col_o,
    output logic       my_turn_o,
    output logic       link_error_o,
    output logic       tx_o,
    input  logic       rx_i
);
    localparam int SUB_W = $clog2(BIT_CYCLES);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W = $clog2(RETRIES + 2);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BIT_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_PEN  = SUB_W'(BIT_CYCLES - 2);
    localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(BIT_CYCLES / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(RETRIES);
    localparam logic [2:0]       ACK_CODE = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_TX_MOVE, S_WAIT_ACK, S_RX_FRAME, S_TX_ACK, S_ERROR
    } state_e;

    // Frame bit i is transmitted i-th: start, d0, d1, d2, odd parity, stop.
    function automatic logic [5:0] frame_of(input logic [2:0] col);
        return {1'b0, ~^col, col, 1'b1};
    endfunction

    state_e           state_q, state_d, prior_q, prior_d;
    logic             my_turn_q, my_turn_d, link_error_q, link_error_d;
    logic             remote_valid_q, remote_valid_d;
    logic [2:0]       remote_col_q, remote_col_d;
    logic             tx_q, tx_d, tx_busy_q, tx_busy_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [SUB_W-1:0] tx_sub_q, tx_sub_d;
    logic [5:0]       tx_frame_q, tx_frame_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [SUB_W-1:0] rx_sub_q, rx_sub_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [3:0]       rx_data_q, rx_data_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RTY_W-1:0] retry_q, retry_d;

    logic tx_done, tx_last_next, rx_edge, par_ok;

    assign rx_edge = rx_sync_q & ~rx_prev_q;
    assign par_ok  = ^rx_data_q;   // d0..d2 plus parity must hold an odd count

    always_comb begin
        state_d        = state_q;
        prior_d        = prior_q;
        my_turn_d      = my_turn_q;
        link_error_d   = link_error_q;
        remote_valid_d = 1'b0;
        remote_col_d   = remote_col_q;
        tx_d           = tx_q;
        tx_busy_d      = tx_busy_q;
        tx_bit_d       = tx_bit_q;
        tx_sub_d       = tx_sub_q;
        tx_frame_d     = tx_frame_q;
        rx_sub_d       = rx_sub_q;
        rx_bit_d       = rx_bit_q;
        rx_data_d      = rx_data_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        local_ready_o  = 1'b0;
        illegal_move_o = 1'b0;
        tx_done        = 1'b0;
        tx_last_next   = 1'b0;

        // Serialiser: tx_bit/tx_sub describe the bit currently on tx_o.
        if (tx_busy_q) begin
            tx_last_next = (tx_bit_q == 3'd5) && (tx_sub_q == SUB_PEN);
            if (tx_sub_q == SUB_LAST) begin
                tx_sub_d = '0;
                if (tx_bit_q == 3'd5) begin
                    tx_busy_d = 1'b0;
                    tx_done   = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_d     = tx_frame_q[tx_bit_q + 3'd1];
                end
            end else begin
                tx_sub_d = tx_sub_q + SUB_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rx_edge) begin
                    prior_d  = S_IDLE;
                    state_d  = S_RX_FRAME;
                    rx_sub_d = SUB_HALF;
                    rx_bit_d = 3'd0;
                end else if (my_turn_q && local_valid_i) begin
                    if (local_col_i == ACK_CODE) begin
                        illegal_move_o = 1'b1;
                    end else begin
                        local_ready_o = 1'b1;
                        tx_frame_d    = frame_of(local_col_i);
                        tx_d          = 1'b1;
                        tx_busy_d     = 1'b1;
                        tx_bit_d      = 3'd0;
                        tx_sub_d      = '0;
                        retry_d       = '0;
                        state_d       = S_TX_MOVE;
                    end
                end
            end
            S_TX_MOVE: begin
                if (tx_done) begin
                    timer_d = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (rx_edge) begin
                    prior_d  = S_WAIT_ACK;
                    state_d  = S_RX_FRAME;
                    rx_sub_d = SUB_HALF;
                    rx_bit_d = 3'd0;
                end else if (timer_q == TMR_LAST) begin
                    if (retry_q == RTY_MAX) begin
                        link_error_d = 1'b1;
                        state_d      = S_ERROR;
                    end else begin
                        // Resend the frame still held in tx_frame_q.
                        retry_d   = retry_q + RTY_W'(1);
                        tx_d      = 1'b1;
                        tx_busy_d = 1'b1;
                        tx_bit_d  = 3'd0;
                        tx_sub_d  = '0;
                        state_d   = S_TX_MOVE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_RX_FRAME: begin
                if (rx_sub_q != '0) begin
                    rx_sub_d = rx_sub_q - SUB_W'(1);
                end else begin
                    rx_sub_d = SUB_LAST;
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd0) begin
                        // Start bit gone at mid-bit: it was a glitch.
                        if (!rx_sync_q) begin
                            state_d = prior_q;
                        end
                    end else if (rx_bit_q != 3'd5) begin
                        rx_data_d = {rx_sync_q, rx_data_q[3:1]};
                    end else if (!par_ok || rx_sync_q) begin
                        link_error_d = 1'b1;
                        state_d      = S_ERROR;
                    end else if (rx_data_q[2:0] == ACK_CODE) begin
                        if (prior_q == S_WAIT_ACK) begin
                            my_turn_d = 1'b0;
                            retry_d   = '0;
                            state_d   = S_IDLE;
                        end else begin
                            state_d = prior_q;
                        end
                    end else begin
                        // With my_turn already set this is a resend of a move
                        // whose ACK was lost: ACK again, deliver nothing.
                        if (!my_turn_q) begin
                            remote_col_d   = rx_data_q[2:0];
                            remote_valid_d = 1'b1;
                        end
                        state_d = S_TX_ACK;
                    end
                end
            end
            S_TX_ACK: begin
                // First cycle here is idle so the ACK start bit trails
                // remote_valid_o by one cycle.
                if (!tx_busy_q) begin
                    tx_frame_d = frame_of(ACK_CODE);
                    tx_d       = 1'b1;
                    tx_busy_d  = 1'b1;
                    tx_bit_d   = 3'd0;
                    tx_sub_d   = '0;
                end
                if (tx_last_next) begin
                    my_turn_d = 1'b1;
                end
                if (tx_done) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                tx_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Link down or restart overrides everything decided above.
        if (!link_up_i || restart_i) begin
            state_d        = S_IDLE;
            my_turn_d      = player_i;
            link_error_d   = 1'b0;
            remote_valid_d = 1'b0;
            tx_d           = 1'b0;
            tx_busy_d      = 1'b0;
            timer_d        = '0;
            retry_d        = '0;
            local_ready_o  = 1'b0;
            illegal_move_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            prior_q        <= S_IDLE;
            my_turn_q      <= 1'b0;
            link_error_q   <= 1'b0;
            remote_valid_q <= 1'b0;
            remote_col_q   <= 3'd0;
            tx_q           <= 1'b0;
            tx_busy_q      <= 1'b0;
            tx_bit_q       <= 3'd0;
            tx_sub_q       <= '0;
            tx_frame_q     <= 6'd0;
            rx_meta_q      <= 1'b0;
            rx_sync_q      <= 1'b0;
            rx_prev_q      <= 1'b0;
            rx_sub_q       <= '0;
            rx_bit_q       <= 3'd0;
            rx_data_q      <= 4'd0;
            timer_q        <= '0;
            retry_q        <= '0;
        end else begin
            state_q        <= state_d;
            prior_q        <= prior_d;
            my_turn_q      <= my_turn_d;
            link_error_q   <= link_error_d;
            remote_valid_q <= remote_valid_d;
            remote_col_q   <= remote_col_d;
            tx_q           <= tx_d;
            tx_busy_q      <= tx_busy_d;
            tx_bit_q       <= tx_bit_d;
            tx_sub_q       <= tx_sub_d;
            tx_frame_q     <= tx_frame_d;
            rx_meta_q      <= rx_i;
            rx_sync_q      <= rx_meta_q;
            rx_prev_q      <= rx_sync_q;
            rx_sub_q       <= rx_sub_d;
            rx_bit_q       <= rx_bit_d;
            rx_data_q      <= rx_data_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
        end
    end

    assign remote_valid_o = remote_valid_q;
    assign remote_col_o   = remote_col_q;
    assign my_turn_o      = my_turn_q;
    assign link_error_o   = link_error_q;
    assign tx_o           = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_move_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_link_ctrl
// Purpose  : Self-checking bench for move_link_ctrl: two instances (A moves
//            first, B second) that can be looped tx->rx or fed by hand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_link_ctrl;
    logic clk = 1'b0;
    logic rst_n, link_up, restart, player_a, player_b;
    logic lv_a, lv_b, sel_loop, inj_a, inj_b;
    logic [2:0] col_a, col_b;
    logic a_rdy, a_ill, a_rv, a_turn, a_err, a_tx;
    logic b_rdy, b_ill, b_rv, b_turn, b_err, b_tx;
    logic [2:0] a_rc, b_rc;
    logic rx_a, rx_b;

    int errors = 0;
    int checks = 0;
    int rv_a_cnt = 0, rv_b_cnt = 0, b_rises = 0;
    logic b_tx_prev = 1'b0;

    always #5 clk = ~clk;

    assign rx_a = sel_loop ? b_tx : inj_a;
    assign rx_b = sel_loop ? a_tx : inj_b;

    move_link_ctrl #(.BIT_CYCLES(8), .ACK_TIMEOUT(64), .RETRIES(3)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .player_i(player_a), .link_up_i(link_up),
        .restart_i(restart), .local_valid_i(lv_a), .local_col_i(col_a),
        .local_ready_o(a_rdy), .illegal_move_o(a_ill), .remote_valid_o(a_rv),
        .remote_col_o(a_rc), .my_turn_o(a_turn), .link_error_o(a_err),
        .tx_o(a_tx), .rx_i(rx_a)
    );

    move_link_ctrl #(.BIT_CYCLES(8), .ACK_TIMEOUT(64), .RETRIES(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .player_i(player_b), .link_up_i(link_up),
        .restart_i(restart), .local_valid_i(lv_b), .local_col_i(col_b),
        .local_ready_o(b_rdy), .illegal_move_o(b_ill), .remote_valid_o(b_rv),
        .remote_col_o(b_rc), .my_turn_o(b_turn), .link_error_o(b_err),
        .tx_o(b_tx), .rx_i(rx_b)
    );

    always @(posedge clk) begin
        if (a_rv) rv_a_cnt <= rv_a_cnt + 1;
        if (b_rv) rv_b_cnt <= rv_b_cnt + 1;
        b_tx_prev <= b_tx;
        if (b_tx && !b_tx_prev) b_rises <= b_rises + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // All tasks start and end on a falling clock edge.
    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic offer(input bit who, input logic [2:0] col,
                         output logic rdy, output logic ill);
        if (who) begin lv_b = 1'b1; col_b = col; end
        else     begin lv_a = 1'b1; col_a = col; end
        #1;
        rdy = who ? b_rdy : a_rdy;
        ill = who ? b_ill : a_ill;
        @(negedge clk);
        lv_a = 1'b0;
        lv_b = 1'b0;
    endtask

    // Sample a frame at mid-bit; call on the first cycle of its start bit.
    task automatic grab(input bit who, output logic [5:0] bits);
        bits = '0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < 6; b++) begin
            bits = {bits[4:0], (who ? b_tx : a_tx)};
            if (b < 5) repeat (8) @(negedge clk);
        end
    endtask

    // Drive a frame into B's rx; bits[5] is the start bit.
    task automatic send_b(input logic [5:0] bits);
        for (int i = 5; i >= 0; i--) begin
            inj_b = bits[i];
            repeat (8) @(negedge clk);
        end
        inj_b = 1'b0;
    endtask

    typedef struct {
        logic [2:0] col;
        logic       ill;
        logic [5:0] bits;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy, ill, any;
        logic [5:0] bits;
        logic [5:0] fb[4];
        int n_rv, n_mt, n_af, rv0, r0, k, off;

        vecs[0] = '{col: 3'd5, ill: 1'b0, bits: 6'b110110};
        vecs[1] = '{col: 3'd0, ill: 1'b0, bits: 6'b100010};
        vecs[2] = '{col: 3'd3, ill: 1'b0, bits: 6'b111010};
        vecs[3] = '{col: 3'd7, ill: 1'b1, bits: 6'b000000};
        vecs[4] = '{col: 3'd6, ill: 1'b0, bits: 6'b101110};
        vecs[5] = '{col: 3'd1, ill: 1'b0, bits: 6'b110000};

        rst_n = 1'b0; link_up = 1'b0; restart = 1'b0;
        player_a = 1'b1; player_b = 1'b0;
        lv_a = 1'b0; lv_b = 1'b0; col_a = 3'd0; col_b = 3'd0;
        sel_loop = 1'b0; inj_a = 1'b0; inj_b = 1'b0;

        // Reset state
        #3;
        check("reset tx", a_tx, 0);
        check("reset my_turn", a_turn, 0);
        check("reset link_error", a_err, 0);
        check("reset remote_valid", a_rv, 0);
        check("reset remote_col", a_rc, 0);
        check("reset local_ready", a_rdy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        link_up = 1'b1;
        @(negedge clk);
        check("link up my_turn", a_turn, 1);
        check("link up tx", a_tx, 0);

        // Table: local offers from A, frame on tx or illegal pulse
        for (int i = 0; i < 6; i++) begin
            pulse_restart();
            offer(1'b0, vecs[i].col, rdy, ill);
            check("vec local_ready", rdy, !vecs[i].ill);
            check("vec illegal_move", ill, vecs[i].ill);
            if (vecs[i].ill) begin
                any = 1'b0;
                for (int c = 0; c < 48; c++) begin
                    any |= a_tx;
                    @(negedge clk);
                end
                check("illegal tx idle", any, 0);
                check("illegal my_turn kept", a_turn, 1);
            end else begin
                grab(1'b0, bits);
                check("vec frame bits", bits, vecs[i].bits);
            end
        end

        // Loopback: A sends col 3, B delivers and ACKs
        sel_loop = 1'b1;
        pulse_restart();
        check("loop a my_turn", a_turn, 1);
        check("loop b my_turn", b_turn, 0);
        rv0 = rv_b_cnt;
        offer(1'b0, 3'd3, rdy, ill);
        check("loop local_ready", rdy, 1);
        n_rv = -1; n_mt = -1; n_af = -1;
        for (int n = 0; n < 150; n++) begin
            if (n_rv < 0 && b_rv) n_rv = n;
            if (n_mt < 0 && b_turn) n_mt = n;
            if (n_af < 0 && !a_turn) n_af = n;
            @(negedge clk);
        end
        check("rx latency to remote_valid", n_rv, 47);
        check("b remote_col", b_rc, 3);
        check("b remote_valid count", rv_b_cnt - rv0, 1);
        check("b my_turn rise cycle", n_mt, 95);
        check("a my_turn fall cycle", n_af, 95);

        // B answers with col 2
        rv0 = rv_a_cnt;
        offer(1'b1, 3'd2, rdy, ill);
        check("b local_ready", rdy, 1);
        for (int n = 0; n < 120 && !a_rv; n++) @(negedge clk);
        check("a remote_valid seen", a_rv, 1);
        check("a remote_col", a_rc, 2);
        for (int n = 0; n < 120 && !a_turn; n++) @(negedge clk);
        check("a my_turn back", a_turn, 1);
        check("b my_turn cleared", b_turn, 0);
        repeat (3) @(negedge clk);
        check("a remote_valid count", rv_a_cnt - rv0, 1);
        sel_loop = 1'b0;

        // No ACK: 4 identical frames, then link_error
        pulse_restart();
        offer(1'b0, 3'd6, rdy, ill);
        check("timeout local_ready", rdy, 1);
        any = 1'b0;
        for (int f = 0; f < 4; f++) fb[f] = '0;
        for (int n = 0; n < 460; n++) begin
            k = n / 112;
            off = n % 112;
            if (k < 4 && off < 48 && (off % 8) == 4) fb[k] = {fb[k][4:0], a_tx};
            if (n >= 384) any |= a_tx;
            if (n == 447) check("link_error before last timeout", a_err, 0);
            if (n == 448) check("link_error after retries", a_err, 1);
            @(negedge clk);
        end
        for (int f = 0; f < 4; f++) check("resend frame bits", fb[f], 6'b101110);
        check("no fifth frame", any, 0);
        pulse_restart();
        check("restart clears link_error", a_err, 0);
        check("restart my_turn=player 1", a_turn, 1);
        player_a = 1'b0;
        pulse_restart();
        check("restart my_turn=player 0", a_turn, 0);
        player_a = 1'b1;
        pulse_restart();

        // Bad parity into B
        rv0 = rv_b_cnt;
        r0 = b_rises;
        send_b(6'b101010);
        repeat (5) @(negedge clk);
        check("bad parity link_error", b_err, 1);
        check("bad parity no remote_valid", rv_b_cnt - rv0, 0);
        check("bad parity no ack", b_rises - r0, 0);
        pulse_restart();
        check("restart clears b error", b_err, 0);

        // 2-cycle glitch
        inj_b = 1'b1;
        repeat (2) @(negedge clk);
        inj_b = 1'b0;
        repeat (60) @(negedge clk);
        check("glitch no error", b_err, 0);
        check("glitch no remote_valid", rv_b_cnt - rv0, 0);
        check("glitch no ack", b_rises - r0, 0);

        // Good move col 4, then the same frame again (ACK lost)
        send_b(6'b100100);
        repeat (5) @(negedge clk);
        check("move remote_valid", rv_b_cnt - rv0, 1);
        check("move remote_col", b_rc, 4);
        for (int n = 0; n < 100 && !b_turn; n++) @(negedge clk);
        check("move b my_turn", b_turn, 1);
        send_b(6'b100100);
        for (int n = 0; n < 20 && !b_tx; n++) @(negedge clk);
        check("dup ack start", b_tx, 1);
        grab(1'b1, bits);
        check("dup ack frame bits", bits, 6'b111100);
        repeat (10) @(negedge clk);
        check("dup single remote_valid", rv_b_cnt - rv0, 1);
        check("dup two ack frames", b_rises - r0, 2);
        check("dup no error", b_err, 0);
        check("dup b my_turn", b_turn, 1);

        // Reset mid-frame drops tx at once
        pulse_restart();
        offer(1'b0, 3'd5, rdy, ill);
        repeat (10) @(negedge clk);
        check("tx high before reset", a_tx, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset tx", a_tx, 0);
        check("async reset b remote_col", b_rc, 0);
        check("async reset my_turn", a_turn, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
